four_vote_collector: RTL and testbench

//  Front-end ballot stage for the 4-input majority voter. Synchronises and

---
 rtl/four_vote_collector.sv | 121 ++++++++++++
 tb/tb_four_vote_collector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/four_vote_collector.sv
// Ballot front-end for the 4-input majority voter: synchronises and debounces
// four buttons, then latches sticky ballots during a timed voting session.
module four_vote_collector #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WINDOW_CYCLES   = 1000,
  parameter int unsigned WIN_W           = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] vote_in,
  output logic       vote_a,
  output logic       vote_b,
  output logic       vote_c,
  output logic       vote_d,
  output logic [2:0] ballots_cast,
  output logic       session_busy,
  output logic       done,
  output logic       timeout
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0]    DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OPEN, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       sync1, sync2, deb, deb_q, rise;
  logic [DW-1:0]    deb_cnt [4];
  logic [3:0]       ballots, ballots_nxt, merged;
  logic [2:0]       cast_nxt;
  logic             timeout_nxt;
  logic [WIN_W-1:0] win_cnt, win_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int unsigned i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= vote_in;
      sync2 <= sync1;
      deb_q <= deb;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = deb & ~deb_q;

  function automatic logic [2:0] popcount4(input logic [3:0] b);
    return {2'b00, b[0]} + {2'b00, b[1]} + {2'b00, b[2]} + {2'b00, b[3]};
  endfunction

  // A ballot rising on the closing edge still counts, so closure is judged on the merged set
  always_comb begin
    state_nxt   = state;
    ballots_nxt = ballots;
    cast_nxt    = ballots_cast;
    timeout_nxt = timeout;
    win_nxt     = win_cnt;
    merged      = ballots | rise;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = OPEN;
          ballots_nxt = '0;
          cast_nxt    = '0;
          timeout_nxt = 1'b0;
          win_nxt     = '0;
        end
      end
      OPEN: begin
        ballots_nxt = merged;
        cast_nxt    = popcount4(merged);
        win_nxt     = win_cnt + 1'b1;
        if ((&merged) || (win_cnt == WIN_LAST)) begin
          state_nxt   = DONE;
          timeout_nxt = ~(&merged);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ballots      <= '0;
      ballots_cast <= '0;
      timeout      <= 1'b0;
      win_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      ballots      <= ballots_nxt;
      ballots_cast <= cast_nxt;
      timeout      <= timeout_nxt;
      win_cnt      <= win_nxt;
    end
  end

  assign vote_a       = ballots[0];
  assign vote_b       = ballots[1];
  assign vote_c       = ballots[2];
  assign vote_d       = ballots[3];
  assign session_busy = (state == OPEN);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_four_vote_collector.sv
// Scoreboard bench for four_vote_collector: sessions push their expected
// close record, a negedge monitor checks it whenever done pulses.
module tb_four_vote_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] vote_in;
  logic       vote_a, vote_b, vote_c, vote_d;
  logic [2:0] ballots_cast;
  logic       session_busy, done, timeout;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] b;
    logic [2:0] n;
    logic       t;
    logic       y;
    int         at;
  } exp_t;

  exp_t sb[$];

  four_vote_collector #(
    .DEBOUNCE_CYCLES(4),
    .WINDOW_CYCLES  (50),
    .WIN_W          (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .vote_in     (vote_in),
    .vote_a      (vote_a),
    .vote_b      (vote_b),
    .vote_c      (vote_c),
    .vote_d      (vote_d),
    .ballots_cast(ballots_cast),
    .session_busy(session_busy),
    .done        (done),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      chk("done_width", int'(prev_done), 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending session (cycle %0d)", cyc);
      end else begin
        int nv;
        e  = sb.pop_front();
        nv = int'(vote_a) + int'(vote_b) + int'(vote_c) + int'(vote_d);
        chk("close_ballots", int'({vote_d, vote_c, vote_b, vote_a}), int'(e.b));
        chk("close_cast", int'(ballots_cast), int'(e.n));
        chk("close_timeout", int'(timeout), int'(e.t));
        chk("close_voter_y", int'(nv >= 3), int'(e.y));
        chk("close_cycle", cyc, e.at);
      end
    end
    prev_done = done;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic start_session(output int s);
    s     = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    if (k == 200) begin
      checks++;
      errors++;
      $display("FAIL %s: got no done within 200 cycles expected a done pulse", name);
    end
    tick(2);
  endtask

  task automatic push(input logic [3:0] b, input logic [2:0] n, input logic t,
                      input logic y, input int at);
    exp_t e;
    e.b = b; e.n = n; e.t = t; e.y = y; e.at = at;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst = 1'b1; start = 1'b0; vote_in = '0;
    tick(3);
    chk("reset_votes", int'({vote_d, vote_c, vote_b, vote_a}), 0);
    chk("reset_cast", int'(ballots_cast), 0);
    chk("reset_busy", int'(session_busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_timeout", int'(timeout), 0);
    rst = 1'b0;
    tick(3);

    // Glitch of DEBOUNCE_CYCLES-1 cycles never latches; session times out empty
    start_session(s);
    push(4'b0000, 3'd0, 1'b1, 1'b0, s + 51);
    wait_cyc(s + 5);  vote_in[0] = 1'b1;
    wait_cyc(s + 8);  vote_in[0] = 1'b0;
    wait_cyc(s + 20);
    chk("glitch_vote_a", int'(vote_a), 0);
    chk("glitch_cast", int'(ballots_cast), 0);
    chk("glitch_busy", int'(session_busy), 1);
    wait_done("glitch_done");

    // Staggered a,b,c,d: d pressed at s+8 latches at s+15, closing on that edge
    start_session(s);
    push(4'b1111, 3'd4, 1'b0, 1'b1, s + 15);
    for (int k = 2; k <= 20; k++) begin
      wait_cyc(s + k);
      for (int i = 0; i < 4; i++) vote_in[i] = (k >= 2 + 2 * i) && (k < 12 + 2 * i);
    end
    chk("early_sb_empty", sb.size(), 0);
    chk("early_busy", int'(session_busy), 0);
    chk("early_hold_cast", int'(ballots_cast), 4);
    tick(8);

    // Timeout with a and c: done 51 cycles after start is presented
    start_session(s);
    push(4'b0101, 3'd2, 1'b1, 1'b0, s + 51);
    wait_cyc(s + 2);  vote_in[0] = 1'b1;
    wait_cyc(s + 4);  vote_in[2] = 1'b1;
    wait_cyc(s + 12); vote_in = '0;
    wait_done("timeout_done");
    chk("timeout_hold", int'({timeout, ballots_cast, vote_d, vote_c, vote_b, vote_a}),
        int'({1'b1, 3'd2, 4'b0101}));
    tick(8);

    // b held before start produces no rise; release and re-press latches after 7 edges
    vote_in[1] = 1'b1;
    tick(12);
    start_session(s);
    push(4'b0010, 3'd1, 1'b1, 1'b0, s + 51);
    wait_cyc(s + 10);
    chk("preheld_vote_b", int'(vote_b), 0);
    chk("preheld_cast", int'(ballots_cast), 0);
    vote_in[1] = 1'b0;
    wait_cyc(s + 20); vote_in[1] = 1'b1;
    wait_cyc(s + 26);
    chk("repress_before", int'(vote_b), 0);
    wait_cyc(s + 27);
    chk("repress_latch", int'(vote_b), 1);
    wait_done("preheld_done");
    vote_in = '0;
    tick(10);

    // start while OPEN must not extend the window
    start_session(s);
    push(4'b0001, 3'd1, 1'b1, 1'b0, s + 51);
    wait_cyc(s + 2);  vote_in[0] = 1'b1;
    wait_cyc(s + 10); start = 1'b1;
    wait_cyc(s + 11); start = 1'b0;
    wait_cyc(s + 14); vote_in = '0;
    wait_done("restart_ignored_done");
    tick(8);

    // rst mid-session clears everything at once and yields no done
    start_session(s);
    wait_cyc(s + 2);  vote_in[0] = 1'b1;
    wait_cyc(s + 12);
    chk("pre_rst_vote_a", int'(vote_a), 1);
    rst = 1'b1;
    #1;
    chk("rst_outputs", int'({timeout, done, session_busy, ballots_cast, vote_d, vote_c, vote_b, vote_a}), 0);
    vote_in = '0;
    @(negedge clk);
    rst = 1'b0;
    tick(60);
    chk("rst_no_done_sb", sb.size(), 0);
    chk("rst_idle_busy", int'(session_busy), 0);

    // a,b,d pressed together all latch on one edge
    start_session(s);
    push(4'b1011, 3'd3, 1'b1, 1'b1, s + 51);
    wait_cyc(s + 2);  vote_in = 4'b1011;
    wait_cyc(s + 8);
    chk("simul_cast_before", int'(ballots_cast), 0);
    wait_cyc(s + 9);
    chk("simul_cast_after", int'(ballots_cast), 3);
    chk("simul_votes", int'({vote_d, vote_c, vote_b, vote_a}), 4'b1011);
    wait_cyc(s + 15); vote_in = '0;
    wait_done("simul_done");

    chk("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
